mux_sel_scanner: RTL and testbench
==================================

Name: mux_sel_scanner

Overview:
- Upstream driver for the 8-input, 16-bit mux tree (mux3 built from two mux2 stages).
- Holds an 8-entry byte bank that feeds the mux data inputs (f1..f8).
- On start, steps the four select lines through all 16 codes and samples the mux output for each code.
- Presents each result as a valid/ready stream to the downstream consumer.

Parameters:
- DATA_W, 8, width of each bank entry and of each mux data input.
- HOLD_CYCLES, 1, cycles the select code is held stable before the mux output is sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  bank write strobe.
- wr_addr  in  3  bank index; 0 = f1 … 7 = f8.
- wr_data  in  DATA_W  bank write data.
- start  in  1  begin a 16-code scan.
- f1..f8  out  DATA_W each  registered bank contents, driven to the mux data inputs.
- x, y, z, t  out  1 each  registered select lines.
- mux_in  in  2*DATA_W  mux tree output (out3).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_code  out  4  select code of the current result, ordered {x,y,z,t}.
- res_data  out  2*DATA_W  sampled mux_in for that code.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs):
  - bank entries f1..f8 = 0; x, y, z, t = 0; res_valid = 0; res_code = 0; res_data = 0; busy = 0; done = 0.
  - FSM returns to IDLE. This also applies mid-scan; any partial scan is discarded.
- Select code: the internal 4-bit register code drives {x,y,z,t} = code[3:0] directly from flops, with no glitch path.
- FSM states:
  - IDLE: busy = 0.
    - wr_en writes wr_data into bank[wr_addr] at the clock edge.
    - start (wr_en clear) sets code = 0, loads hold counter = HOLD_CYCLES-1, busy = 1, goes to SETTLE.
    - start and wr_en in the same cycle: the write is performed and start is ignored.
  - SETTLE: counter decrements each cycle; at 0 goes to CAPTURE.
  - CAPTURE: one cycle; latches res_data <= mux_in and res_code <= code, sets res_valid = 1, goes to PRESENT.
  - PRESENT: res_data and res_code hold stable while res_valid && !res_ready.
    - On handshake (res_valid && res_ready): res_valid = 0.
    - If code == 15: done = 1 for one cycle, busy = 0, goes to IDLE, code returns to 0.
    - Otherwise: code increments, counter reloads, goes to SETTLE.
- Latency: start to first res_valid = HOLD_CYCLES + 2 cycles; consecutive results are ≥ HOLD_CYCLES + 2 cycles apart.
- While busy: wr_en and start are ignored, so the bank is frozen during a scan.
- res_ready while res_valid = 0 has no effect.
- No wrap-around beyond code 15; exactly 16 results per scan.
- mux_in is sampled only in CAPTURE; changes at other times are ignored.

Optional Feature:
- Macro SCAN_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (2*DATA_W).
  - checksum is cleared at the start accept and reset, and adds res_data (mod 2^(2*DATA_W)) at each handshake.
  - The final value is stable from the done pulse until the next start.
- Undefined: no port, no adder logic.

Test Plan:
- Write bank with a5, b8, c7, d2, a5, b8, c7, d2 via wr_en, addresses 0..7 -> f1..f8 read back those values; x, y, z, t = 0.
- Bench stub drives mux_in = {12'hA50, x, y, z, t}; start with res_ready tied 1, HOLD_CYCLES = 1 -> 16 results, res_code 0..15, res_data 16'hA500..16'hA50F, each pair 3 cycles apart, done pulses once, busy falls the same cycle.
- res_ready held 0 for 5 cycles on code 2 -> res_valid, res_code = 2 and res_data = 16'hA502 hold stable; code does not advance; the scan resumes on release.
- Assert rst in SETTLE of code 7 -> next cycle busy = 0, res_valid = 0, {x,y,z,t} = 0, bank = 0; a new start restarts at code 0.
- wr_en (addr 3, data 8'h11) and start pulses during a scan -> f4 unchanged, scan continues unaffected; start+wr_en together in IDLE -> write occurs, no scan begins.
- SCAN_CHECKSUM_EN defined, stub as in scenario 2 -> checksum = 16'h5078 after done (16 × 16'hA500 + 0+…+15 = 120, i.e. 16'h0000 + 16'h0078 + wrap from the A500 sum).

Source files
------------

// File: rtl/mux_sel_scanner.sv
// Scan driver for the 8-input mux tree: holds the byte bank on f1..f8, walks {x,y,z,t}
// through all 16 codes and streams each sampled mux output. SCAN_CHECKSUM_EN adds a result checksum.
module mux_sel_scanner #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  output logic [DATA_W-1:0]     f1,
  output logic [DATA_W-1:0]     f2,
  output logic [DATA_W-1:0]     f3,
  output logic [DATA_W-1:0]     f4,
  output logic [DATA_W-1:0]     f5,
  output logic [DATA_W-1:0]     f6,
  output logic [DATA_W-1:0]     f7,
  output logic [DATA_W-1:0]     f8,
  output logic                  x,
  output logic                  y,
  output logic                  z,
  output logic                  t,
  input  logic [2*DATA_W-1:0]   mux_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [3:0]            res_code,
  output logic [2*DATA_W-1:0]   res_data,
  output logic                  busy,
`ifdef SCAN_CHECKSUM_EN
  output logic [2*DATA_W-1:0]   checksum,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, PRESENT} state_t;

  localparam logic [3:0] RELOAD = 4'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        code, code_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] bank [8];
  logic              accept_start;
  logic              handshake;
  logic              capture;
  logic              last;

  assign accept_start = (state == IDLE) && start && !wr_en;
  assign handshake    = res_valid && res_ready;

  // Selects come straight from the code flops so the mux tree never sees a decode glitch.
  assign {x, y, z, t} = code;
  assign busy = (state != IDLE);

  assign f1 = bank[0];
  assign f2 = bank[1];
  assign f3 = bank[2];
  assign f4 = bank[3];
  assign f5 = bank[4];
  assign f6 = bank[5];
  assign f7 = bank[6];
  assign f8 = bank[7];

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          code_nxt  = 4'd0;
          cnt_nxt   = RELOAD;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nxt = CAPTURE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (handshake) begin
          if (code == 4'd15) begin
            last      = 1'b1;
            code_nxt  = 4'd0;
            state_nxt = IDLE;
          end else begin
            code_nxt  = code + 4'd1;
            cnt_nxt   = RELOAD;
            state_nxt = SETTLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      code      <= 4'd0;
      cnt       <= 4'd0;
      res_valid <= 1'b0;
      res_code  <= 4'd0;
      res_data  <= '0;
      done      <= 1'b0;
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      cnt   <= cnt_nxt;
      done  <= last;
      // Bank is writable only while idle so it stays frozen for a whole scan.
      if ((state == IDLE) && wr_en) bank[wr_addr] <= wr_data;
      if (capture) begin
        res_data  <= mux_in;
        res_code  <= code;
        res_valid <= 1'b1;
      end else if (handshake) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef SCAN_CHECKSUM_EN
  function automatic logic [2*DATA_W-1:0] wrap_add(input logic [2*DATA_W-1:0] a,
                                                   input logic [2*DATA_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || accept_start) checksum <= '0;
    else if (handshake)      checksum <= wrap_add(checksum, res_data);
  end
`endif

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner with a stub mux returning {12'hA50, x, y, z, t}.
module tb_mux_sel_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        start = 1'b0;
  logic [7:0]  f [8];
  logic        x, y, z, t;
  logic [15:0] mux_in;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [3:0]  res_code;
  logic [15:0] res_data;
  logic        busy;
  logic        done;
`ifdef SCAN_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] pat [8];

  always #5 clk = ~clk;

  assign mux_in = {12'hA50, x, y, z, t};

  mux_sel_scanner #(.DATA_W(8), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start),
    .f1(f[0]), .f2(f[1]), .f3(f[2]), .f4(f[3]), .f5(f[4]), .f6(f[5]), .f7(f[6]), .f8(f[7]),
    .x(x), .y(y), .z(z), .t(t), .mux_in(mux_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code), .res_data(res_data),
    .busy(busy),
`ifdef SCAN_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("valid_seen", {31'd0, res_valid}, 32'd1);
  endtask

  // Runs a scan up to last_code; stalls 5 cycles on stall_code; intrudes with wr_en/start on code 4.
  task automatic run_scan(input int stall_code, input int last_code, input bit intrude);
    int prev;
    prev = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    for (int k = 0; k <= last_code; k++) begin
      wait_valid();
      chk("res_code", {28'd0, res_code}, k);
      chk("res_data", {16'd0, res_data}, 32'hA500 + k);
      chk("spacing", cyc - prev, (k == stall_code + 1) ? 8 : 3);
      prev = cyc;
      if (k == stall_code) begin
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_valid", {31'd0, res_valid}, 32'd1);
          chk("stall_code", {28'd0, res_code}, k);
          chk("stall_data", {16'd0, res_data}, 32'hA500 + k);
          chk("stall_sel", {28'd0, x, y, z, t}, k);
        end
        res_ready = 1'b1;
      end
      if (intrude && k == 4) begin
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h11; start = 1'b1;
      end
      step();
      wr_en = 1'b0; start = 1'b0;
    end
    if (last_code == 15) begin
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("valid_clear", {31'd0, res_valid}, 32'd0);
      step();
      chk("done_single", {31'd0, done}, 32'd0);
      chk("sel_home", {28'd0, x, y, z, t}, 32'd0);
`ifdef SCAN_CHECKSUM_EN
      chk("checksum", {16'd0, checksum}, 32'h5078);
`endif
    end
  endtask

  initial begin
    pat = '{8'ha5, 8'hb8, 8'hc7, 8'hd2, 8'ha5, 8'hb8, 8'hc7, 8'hd2};

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sel", {28'd0, x, y, z, t}, 32'd0);
    chk("rst_code", {28'd0, res_code}, 32'd0);
    chk("rst_data", {16'd0, res_data}, 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_bank", {24'd0, f[i]}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = pat[i];
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) chk("bank_wr", {24'd0, f[i]}, {24'd0, pat[i]});
    chk("idle_sel", {28'd0, x, y, z, t}, 32'd0);

    // Full scan, consumer always ready.
    run_scan(-10, 15, 1'b0);

    // Back-pressure on code 2.
    run_scan(2, 15, 1'b0);

    // Reset while settling code 7.
    run_scan(-10, 6, 1'b0);
    chk("pre_rst_sel", {28'd0, x, y, z, t}, 32'd7);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_sel", {28'd0, x, y, z, t}, 32'd0);
    for (int i = 0; i < 8; i++) chk("abort_bank", {24'd0, f[i]}, 32'd0);
    run_scan(-10, 15, 1'b0);

    // Writes and starts during a scan are ignored.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hd2;
    step();
    wr_en = 1'b0;
    chk("f4_setup", {24'd0, f[3]}, 32'hd2);
    run_scan(-10, 15, 1'b1);
    chk("f4_frozen", {24'd0, f[3]}, 32'hd2);

    // start together with wr_en in IDLE: write only.
    wr_en = 1'b1; start = 1'b1; wr_addr = 3'd5; wr_data = 8'h5a;
    step();
    wr_en = 1'b0; start = 1'b0;
    chk("combo_write", {24'd0, f[5]}, 32'h5a);
    chk("combo_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("combo_idle_busy", {31'd0, busy}, 32'd0);
      chk("combo_idle_valid", {31'd0, res_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
